pwm_driver: RTL and testbench
=============================

PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 1: number of clk cycles per PWM tick; legal range 1..256.
REQ-002 Parameter SLEW, default 8: maximum duty change per PWM period; legal range 1..255; used only when PWM_SLEW_LIMIT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 pw  input  8  duty command produced by fuzzylogiccontroller; 0 = off, 255 = fully on.
REQ-006 en  input  1  run request; level-sensitive.
REQ-007 pwm_out  output  1  registered PWM waveform.
REQ-008 period_start  output  1  one-clk pulse marking the first cycle of each PWM period.
REQ-009 duty_active  output  8  duty value applied in the current period.
REQ-010 busy  output  1  high when the FSM is in RUN or DRAIN.

Function
REQ-011 Internal prescaler counts 0..PRESCALE-1 and produces a tick when it wraps; PRESCALE=1 gives a tick every clk.
REQ-012 Period counter cnt counts 0..254 on each tick and wraps from 254 to 0; one period equals 255 ticks.
REQ-013 pwm_out shall be high for exactly duty_active ticks of each period, starting at cnt=0: 0 gives constant low, 255 gives constant high with no glitch at wrap.
REQ-014 FSM states:
  - IDLE: cnt=0, prescaler=0, pwm_out=0, busy=0.
  - RUN: normal PWM output.
  - DRAIN: finish the current period with en low.
REQ-015 IDLE->RUN when en=1; on entry, cnt starts at 0, period_start pulses, and duty_active loads per REQ-018/REQ-019.
REQ-016 RUN->DRAIN when en=0; DRAIN->IDLE at the end of the period (tick with cnt=254); DRAIN->RUN when en=1 again, with no counter restart and no extra period_start.
REQ-017 duty_active updates only at a period boundary (tick with cnt=254, or entry to RUN); a pw change mid-period has no effect until the next period.
REQ-018 With slew limiting: if pw > duty_active+SLEW, add SLEW; if pw < duty_active-SLEW, subtract SLEW; otherwise load pw. Comparisons use 9-bit arithmetic with no wrap-around, so the result is clamped to 0..255.
REQ-019 Without slew limiting: duty_active <= pw at each boundary.
REQ-020 period_start pulses in the same cycle as the first pwm_out cycle of each period; it never pulses in IDLE.
REQ-021 If en toggles within a single tick interval, only its value at the tick or at the boundary is acted on; the FSM never skips a period end.

Reset
REQ-022 On rst_n=0: immediately, asynchronously, FSM=IDLE; pwm_out=0, period_start=0, duty_active=0, busy=0, cnt=0, prescaler=0.
REQ-023 Deassertion of rst_n is sampled synchronously; the first possible transition to RUN is the first rising clk edge with rst_n=1 and en=1.
REQ-024 Reset mid-period aborts the period with no completion; pwm_out falls in the same instant reset asserts.

Configuration
REQ-025 Macro PWM_SLEW_LIMIT_EN:
  - Defined: REQ-018 applies. duty_active clears to 0 in IDLE, so every start is a soft-start ramp from 0.
  - Undefined: REQ-019 applies, the SLEW parameter is ignored, and duty_active keeps its last value in IDLE.

Verification
REQ-026 PRESCALE=1, macro off, en=1, pw=130 -> each 255-clk period has 130 high clks; period_start every 255 clks.
REQ-027 Macro off, pw=255, then pw=0 -> pwm_out constantly high across 3 wraps, then constantly low starting at the next boundary.
REQ-028 Macro on, SLEW=8, pw=240 from IDLE -> duty_active 8, 16, ..., 240 over 30 periods, then stays at 240; pw=80 next -> 232, 224, ..., 80.
REQ-029 pw changes 110->240 at cnt=50 -> the current period stays at 110 high ticks; the next period has 240 (macro off).
REQ-030 en drops at cnt=100 with pw=130 -> busy stays 1 and the period completes normally through cnt=254, then IDLE with pwm_out=0; en re-raised at cnt=200 -> continues with no restart.
REQ-031 PRESCALE=4, pw=20 -> 80 high clks per 1020-clk period; rst_n pulsed low mid-period -> all outputs 0 asynchronously, and a new period starts on the first edge after release with en=1.

Source files
------------

// File: rtl/pwm_driver.sv
// ---------------------------------------------------------------------------
// pwm_driver
//   8-bit PWM generator driven by the fuzzy-logic controller's duty command.
//   A prescaler divides clk into PWM ticks. A 0..254 period counter advances
//   once per tick, so one PWM period is 255 ticks. The applied duty is latched
//   only at period boundaries.
//
//   Optional feature macro: PWM_SLEW_LIMIT_EN
//     defined   : the duty step per period is limited to SLEW. duty_active
//                 is held at 0 while idle, so every start ramps up from 0.
//     undefined : duty_active takes pw at each boundary and keeps its last
//                 value while idle. SLEW is not used.
//
// Parameters
//   PRESCALE  clk cycles per PWM tick (1..256)
//   SLEW      maximum duty change per period (1..255)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   pw[7:0]       duty command (0 = off, 255 = fully on)
//   en            run request, level-sensitive
//   pwm_out       registered PWM waveform
//   period_start  one-clk pulse on the first cycle of each period
//   duty_active   duty value applied in the current period
//   busy          high while running or draining the last period
// ---------------------------------------------------------------------------
module pwm_driver #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SLEW     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pw,
  input  logic       en,
  output logic       pwm_out,
  output logic       period_start,
  output logic [7:0] duty_active,
  output logic       busy
);

  localparam int unsigned PW_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW_W-1:0] PRESC_MAX = PW_W'(PRESCALE - 1);
  localparam logic [7:0]      CNT_LAST  = 8'd254;

  generate
    if (PRESCALE < 1 || PRESCALE > 256 || SLEW < 1 || SLEW > 255) begin : g_bad_param
      $error("pwm_driver: PRESCALE or SLEW out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW_W-1:0] presc_q, presc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      duty_q, duty_d;
  logic            pwm_q, pwm_d;
  logic            ps_q, ps_d;

  logic            tick;
  logic            boundary;
  logic [7:0]      duty_next;

  assign tick     = (state_q != IDLE) && (presc_q == PRESC_MAX);
  assign boundary = tick && (cnt_q == CNT_LAST);

  // Duty value to load at the next boundary.
`ifdef PWM_SLEW_LIMIT_EN
  logic [7:0] duty_base;
  logic [8:0] pw9, base9, slew9;

  always_comb begin
    // The ramp always starts from 0 when leaving IDLE, even in the first
    // idle cycle where duty_q may still hold the previous run's value.
    duty_base = (state_q == IDLE) ? '0 : duty_q;
    pw9       = {1'b0, pw};
    base9     = {1'b0, duty_base};
    slew9     = 9'(SLEW);
    // 9-bit compares cannot wrap: base+SLEW < 511 and pw+SLEW < 511.
    if (pw9 > base9 + slew9) begin
      duty_next = duty_base + 8'(SLEW);
    end else if (pw9 + slew9 < base9) begin
      duty_next = duty_base - 8'(SLEW);
    end else begin
      duty_next = pw;
    end
  end
`else
  assign duty_next = pw;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RUN/DRAIN only react to en on ticks, and a period
  // end always takes priority, so no period end is ever skipped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (boundary)      state_d = en ? RUN : IDLE;
        else if (tick && !en) state_d = DRAIN;
      end
      DRAIN: begin
        if (boundary)      state_d = en ? RUN : IDLE;
        else if (tick && en)  state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic. pwm_out/period_start are computed from the
  // next-cycle counter and duty so the registered outputs line up with them.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    ps_d    = 1'b0;

    if (state_q == IDLE) begin
      presc_d = '0;
      cnt_d   = '0;
`ifdef PWM_SLEW_LIMIT_EN
      duty_d  = '0;
`endif
      if (en) begin
        duty_d = duty_next;
        ps_d   = 1'b1;
      end
    end else if (tick) begin
      presc_d = '0;
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (en) begin
          duty_d = duty_next;
          ps_d   = 1'b1;
        end
`ifdef PWM_SLEW_LIMIT_EN
        else begin
          duty_d = '0;
        end
`endif
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      presc_d = presc_q + PW_W'(1);
    end

    pwm_d = (state_d != IDLE) && (cnt_d < duty_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign duty_active  = duty_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_driver.sv
module tb_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n, en, pwm_out, period_start, busy;
  logic [7:0] pw, duty_active;
  logic       rst_n4, en4, pwm_out4, period_start4, busy4;
  logic [7:0] pw4, duty_active4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_driver #(.PRESCALE(1), .SLEW(8)) dut (
    .clk(clk), .rst_n(rst_n), .pw(pw), .en(en),
    .pwm_out(pwm_out), .period_start(period_start),
    .duty_active(duty_active), .busy(busy)
  );

  pwm_driver #(.PRESCALE(4), .SLEW(8)) dut4 (
    .clk(clk), .rst_n(rst_n4), .pw(pw4), .en(en4),
    .pwm_out(pwm_out4), .period_start(period_start4),
    .duty_active(duty_active4), .busy(busy4)
  );

  typedef struct {
    logic [7:0] pw;
    int         exp_high;
    int         exp_duty;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance at least one clk, then wait (bounded) for a period_start.
  task automatic wait_ps(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2000);
    check({name, "_ps_seen"}, int'(period_start), 1);
  endtask

  // Called on the negedge where period_start is high (cnt=0); returns on the
  // negedge 255 clks later.
  task automatic measure(input int exp_duty, output int highs, output int bad_duty,
                         output int extra_ps, output int busy_low);
    highs = 0; bad_duty = 0; extra_ps = 0; busy_low = 0;
    for (int k = 0; k < 255; k++) begin
      if (pwm_out) highs++;
      if (int'(duty_active) != exp_duty) bad_duty++;
      if (k > 0 && period_start) extra_ps++;
      if (!busy) busy_low++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vt[6];
    int   h, bd, xp, bl, cnt_ps;
    int   exp4_duty;

    vt[0] = '{pw: 8'd130, exp_high: 130, exp_duty: 130};
    vt[1] = '{pw: 8'd0,   exp_high: 0,   exp_duty: 0};
    vt[2] = '{pw: 8'd255, exp_high: 255, exp_duty: 255};
    vt[3] = '{pw: 8'd1,   exp_high: 1,   exp_duty: 1};
    vt[4] = '{pw: 8'd254, exp_high: 254, exp_duty: 254};
    vt[5] = '{pw: 8'd110, exp_high: 110, exp_duty: 110};

`ifdef PWM_SLEW_LIMIT_EN
    exp4_duty = 8;
`else
    exp4_duty = 20;
`endif

    rst_n = 1'b0; en = 1'b0; pw = 8'd0;
    rst_n4 = 1'b0; en4 = 1'b0; pw4 = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_duty", int'(duty_active), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1; rst_n4 = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_ps", int'(period_start), 0);

`ifndef PWM_SLEW_LIMIT_EN
    // Start from IDLE: first cycle of RUN is the first period cycle.
    pw = 8'd130; en = 1'b1;
    @(negedge clk);
    check("start_ps", int'(period_start), 1);
    check("start_duty", int'(duty_active), 130);
    check("start_pwm", int'(pwm_out), 1);
    check("start_busy", int'(busy), 1);
    measure(130, h, bd, xp, bl);
    check("p130_high", h, 130);
    check("p130_extra_ps", xp, 0);
    check("p130_next_ps", int'(period_start), 1);

    foreach (vt[i]) begin
      pw = vt[i].pw;
      @(negedge clk);
      wait_ps($sformatf("vec%0d", i));
      measure(vt[i].exp_duty, h, bd, xp, bl);
      check($sformatf("vec%0d_high", i), h, vt[i].exp_high);
      check($sformatf("vec%0d_duty", i), bd, 0);
      check($sformatf("vec%0d_extra_ps", i), xp, 0);
      check($sformatf("vec%0d_next_ps", i), int'(period_start), 1);
    end

    // Mid-period pw change (110 -> 240 at cnt=50) waits for the boundary.
    h = 0;
    for (int k = 0; k < 255; k++) begin
      if (pwm_out) h++;
      if (k == 50) pw = 8'd240;
      @(negedge clk);
    end
    check("mid_change_cur_high", h, 110);
    check("mid_change_ps", int'(period_start), 1);
    measure(240, h, bd, xp, bl);
    check("mid_change_next_high", h, 240);
    check("mid_change_next_duty", bd, 0);

    // Full-on across three wraps, then full-off from the next boundary.
    pw = 8'd255;
    @(negedge clk);
    wait_ps("full_on");
    h = 0; cnt_ps = 0;
    for (int k = 0; k < 765; k++) begin
      if (!pwm_out) h++;
      if (period_start) cnt_ps++;
      @(negedge clk);
    end
    check("full_on_low_cycles", h, 0);
    check("full_on_ps_count", cnt_ps, 3);
    pw = 8'd0;
    measure(255, h, bd, xp, bl);
    check("full_on_last_high", h, 255);
    h = 0;
    for (int k = 0; k < 510; k++) begin
      if (pwm_out) h++;
      @(negedge clk);
    end
    check("full_off_high_cycles", h, 0);

    // en drop at cnt=100: period completes, then IDLE.
    pw = 8'd130;
    @(negedge clk);
    wait_ps("drain");
    h = 0; bl = 0;
    for (int k = 0; k < 255; k++) begin
      if (pwm_out) h++;
      if (!busy) bl++;
      if (k == 100) en = 1'b0;
      @(negedge clk);
    end
    check("drain_high", h, 130);
    check("drain_busy_low", bl, 0);
    check("drain_end_busy", int'(busy), 0);
    check("drain_end_pwm", int'(pwm_out), 0);
    check("drain_end_ps", int'(period_start), 0);
    repeat (5) @(negedge clk);
    check("drain_idle_ps", int'(period_start), 0);
    check("drain_idle_busy", int'(busy), 0);
    en = 1'b1;
    @(negedge clk);
    check("restart_ps", int'(period_start), 1);
    check("restart_busy", int'(busy), 1);

    // en low at cnt=100, high again at cnt=200: no restart.
    h = 0; xp = 0; bl = 0;
    for (int k = 0; k < 255; k++) begin
      if (pwm_out) h++;
      if (k > 0 && period_start) xp++;
      if (!busy) bl++;
      if (k == 100) en = 1'b0;
      if (k == 200) en = 1'b1;
      @(negedge clk);
    end
    check("reraise_high", h, 130);
    check("reraise_extra_ps", xp, 0);
    check("reraise_busy_low", bl, 0);
    check("reraise_next_ps", int'(period_start), 1);
    check("reraise_next_busy", int'(busy), 1);
`else
    // Soft-start ramp 8,16,...,240 then hold, then ramp down to 80.
    pw = 8'd240; en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("ramp_up_ps%0d", i), int'(period_start), 1);
      check($sformatf("ramp_up%0d", i), int'(duty_active),
            (8 * (i + 1) > 240) ? 240 : 8 * (i + 1));
      if (i == 31) pw = 8'd80;
      repeat (255) @(negedge clk);
    end
    for (int j = 0; j < 22; j++) begin
      check($sformatf("ramp_dn%0d", j), int'(duty_active),
            (240 - 8 * (j + 1) < 80) ? 80 : 240 - 8 * (j + 1));
      repeat (255) @(negedge clk);
    end
    en = 1'b0;
    repeat (260) @(negedge clk);
    check("slew_idle_busy", int'(busy), 0);
    check("slew_idle_duty", int'(duty_active), 0);
`endif

    // PRESCALE=4 instance: 255 ticks of 4 clks each.
    pw4 = 8'd20; en4 = 1'b1;
    @(negedge clk);
    check("p4_start_ps", int'(period_start4), 1);
    check("p4_start_duty", int'(duty_active4), exp4_duty);
    h = 0; xp = 0;
    for (int k = 0; k < 1020; k++) begin
      if (pwm_out4) h++;
      if (k > 0 && period_start4) xp++;
      @(negedge clk);
    end
    check("p4_high", h, exp4_duty * 4);
    check("p4_extra_ps", xp, 0);
    check("p4_next_ps", int'(period_start4), 1);
    repeat (20) @(negedge clk);
    check("p4_pre_reset_pwm", int'(pwm_out4), 1);
    #1 rst_n4 = 1'b0;
    #1;
    check("p4_async_pwm", int'(pwm_out4), 0);
    check("p4_async_ps", int'(period_start4), 0);
    check("p4_async_duty", int'(duty_active4), 0);
    check("p4_async_busy", int'(busy4), 0);
    @(negedge clk);
    rst_n4 = 1'b1;
    @(negedge clk);
    check("p4_rel_ps", int'(period_start4), 1);
    check("p4_rel_busy", int'(busy4), 1);
    check("p4_rel_duty", int'(duty_active4), exp4_duty);
    check("p4_rel_pwm", int'(pwm_out4), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
